ps2_packet_assembler: RTL
=========================

PS2_PACKET_ASSEMBLER -- requirements
Module: ps2_packet_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, inter-byte timeout in clk cycles (20 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz).
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk, active-low; one clock, no other clock domains.
REQ-004 SHALL have port rx_data  input  8  byte from the PS/2 receiver, valid when rx_done=1.
REQ-005 SHALL have port rx_done  input  1  one-cycle strobe, one received byte.
REQ-006 SHALL have port packet_done  output  1  one-cycle strobe, complete 3-byte packet available.
REQ-007 SHALL have port packet1  output  8  status byte [YV,XV,YS,XS,1,M,R,L].
REQ-008 SHALL have port packet2  output  8  X movement magnitude.
REQ-009 SHALL have port packet3  output  8  Y movement magnitude.
REQ-010 SHALL have port sync_err  output  1  one-cycle strobe, byte discarded or packet aborted.

Function
REQ-011 SHALL implement FSM states WAIT_B1, WAIT_B2, WAIT_B3; only rx_done, timeout or reset cause transitions.
REQ-012 In WAIT_B1 with rx_done=1 and rx_data[3]=1, SHALL latch the byte into an internal byte-1 register and go to WAIT_B2.
REQ-013 In WAIT_B1 with rx_done=1 and rx_data[3]=0, SHALL discard the byte, stay in WAIT_B1 and pulse sync_err the next cycle.
REQ-014 In WAIT_B2 with rx_done=1, SHALL latch the byte into an internal byte-2 register and go to WAIT_B3; no bit-3 check applies.
REQ-015 In WAIT_B3 with rx_done=1, SHALL go to WAIT_B1 and, on the next clock edge, load packet1/2/3 together from byte-1, byte-2 and rx_data.
REQ-016 SHALL assert packet_done for exactly one cycle, the cycle after the third rx_done, coincident with the new packet1..3 values.
REQ-017 SHALL hold packet1..3 stable between packet_done pulses; partial packets SHALL never alter them.
REQ-018 SHALL clear the timeout counter on every rx_done and in WAIT_B1; it counts while in WAIT_B2 or WAIT_B3.
REQ-019 When the counter reaches TIMEOUT_CYCLES-1 in WAIT_B2/WAIT_B3, SHALL abort to WAIT_B1 and pulse sync_err the next cycle.
REQ-020 If timeout expiry and rx_done coincide, SHALL abort first and evaluate rx_data as a WAIT_B1 candidate (REQ-012/013) in the same cycle; sync_err pulses once.
REQ-021 Counter width SHALL be $clog2(TIMEOUT_CYCLES); it SHALL saturate, never wrap.
REQ-022 Output latency SHALL be exactly 1 cycle from the accepting rx_done; back-to-back rx_done on consecutive cycles SHALL be accepted.

Reset
REQ-023 When reset=0 at a clk edge, SHALL enter WAIT_B1, clear the counter, and set packet_done=0, sync_err=0, packet1=8'h08, packet2=8'h00, packet3=8'h00.
REQ-024 Reset mid-packet SHALL discard any partial bytes without a packet_done or sync_err pulse.

Configuration
REQ-025 Macro PS2_PKT_TIMEOUT_EN defined: timeout logic per REQ-018..021 present.
REQ-026 Macro PS2_PKT_TIMEOUT_EN undefined: no counter is synthesized, TIMEOUT_CYCLES is ignored, and only bit-3 sync (REQ-013) resynchronizes the FSM.

Structure
REQ-027 The shared package ps2_pkg SHALL hold the FSM state type, PS2_SYNC_BIT=3, PS2_PKT_BYTES=3 and PS2_STATUS_RESET=8'h08.
REQ-028 The timeout counter SHALL be one sub-module, ps2_rx_timer (inputs clear/enable, output expired), instantiated only under PS2_PKT_TIMEOUT_EN.

Verification
REQ-029 Bytes 08,05,FB at any spacing below the timeout SHALL produce one packet_done with packet1=08, packet2=05, packet3=FB and no sync_err.
REQ-030 Bytes 00,09,10,20 SHALL produce sync_err once (for 00) and then a packet 09,10,20.
REQ-031 With TIMEOUT_CYCLES=100, byte 08, a gap of 100 cycles, then 09,01,02 SHALL produce sync_err after the gap, a packet 09,01,02, and no packet containing 08.
REQ-032 Timeout expiry coincident with rx_done of 0A, then 03,04, SHALL produce one sync_err and a packet 0A,03,04.
REQ-033 reset=0 after bytes 08,05, then reset=1 and 18,01,02 SHALL produce a packet 18,01,02, with packet1=08 and no strobes during reset.
REQ-034 Three back-to-back rx_done cycles (28,FF,80) SHALL produce packet_done on the fourth cycle with those values.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet assembler.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B1 = 2'd0,
        WAIT_B2 = 2'd1,
        WAIT_B3 = 2'd2
    } ps2_state_t;

    localparam int         PS2_SYNC_BIT     = 3;
    localparam int         PS2_PKT_BYTES    = 3;
    localparam logic [7:0] PS2_STATUS_RESET = 8'h08;

    // A status byte always carries a 1 in the sync position.
    function automatic logic is_sync_byte(input logic [7:0] b);
        return b[PS2_SYNC_BIT];
    endfunction

endpackage

// File: rtl/ps2_packet_assembler_if.sv
// Byte-in / packet-out bus between the PS/2 receiver side and the packet assembler.
interface ps2_packet_assembler_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       packet_done;
    logic [7:0] packet1;
    logic [7:0] packet2;
    logic [7:0] packet3;
    logic       sync_err;

    modport master (
        output rx_data, rx_done,
        input  packet_done, packet1, packet2, packet3, sync_err
    );

    modport slave (
        input  rx_data, rx_done,
        output packet_done, packet1, packet2, packet3, sync_err
    );
endinterface

// File: rtl/ps2_rx_timer.sv
// Saturating inter-byte timeout counter; expired is high while enabled at TIMEOUT_CYCLES-1.
module ps2_rx_timer #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Count up while enabled, holding at LIMIT so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/ps2_packet_assembler.sv
// Assembles three PS/2 mouse bytes into a packet, resyncing on status bit 3.
// Optional inter-byte timeout is enabled by defining PS2_PKT_TIMEOUT_EN.
module ps2_packet_assembler
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                         clk,
    input  logic                         reset,
    ps2_packet_assembler_if.slave        bus
);

    ps2_state_t state_r;
    ps2_state_t state_s;
    logic [7:0] byte1_r;
    logic [7:0] byte2_r;
    logic       load_b1_s;
    logic       load_b2_s;
    logic       emit_s;
    logic       err_s;
    logic       timeout_s;

`ifdef PS2_PKT_TIMEOUT_EN
    logic timer_clear_s;
    logic timer_enable_s;

    assign timer_clear_s  = bus.rx_done || (state_r == WAIT_B1);
    assign timer_enable_s = (state_r != WAIT_B1);

    ps2_rx_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= WAIT_B1;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and datapath controls; a timeout aborts first, then the byte is a byte-1 candidate.
    always_comb begin
        state_s   = state_r;
        load_b1_s = 1'b0;
        load_b2_s = 1'b0;
        emit_s    = 1'b0;
        err_s     = 1'b0;
        if (timeout_s) begin
            err_s   = 1'b1;
            state_s = WAIT_B1;
            if (bus.rx_done && is_sync_byte(bus.rx_data)) begin
                load_b1_s = 1'b1;
                state_s   = WAIT_B2;
            end else begin
                load_b1_s = 1'b0;
            end
        end else if (bus.rx_done) begin
            case (state_r)
                WAIT_B1: begin
                    if (is_sync_byte(bus.rx_data)) begin
                        load_b1_s = 1'b1;
                        state_s   = WAIT_B2;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                WAIT_B2: begin
                    load_b2_s = 1'b1;
                    state_s   = WAIT_B3;
                end
                WAIT_B3: begin
                    emit_s  = 1'b1;
                    state_s = WAIT_B1;
                end
                default: begin
                    state_s = WAIT_B1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Byte staging and registered packet outputs; packets change only on emit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte1_r         <= 8'h00;
            byte2_r         <= 8'h00;
            bus.packet1     <= PS2_STATUS_RESET;
            bus.packet2     <= 8'h00;
            bus.packet3     <= 8'h00;
            bus.packet_done <= 1'b0;
            bus.sync_err    <= 1'b0;
        end else begin
            if (load_b1_s) begin
                byte1_r <= bus.rx_data;
            end else begin
                byte1_r <= byte1_r;
            end
            if (load_b2_s) begin
                byte2_r <= bus.rx_data;
            end else begin
                byte2_r <= byte2_r;
            end
            if (emit_s) begin
                bus.packet1 <= byte1_r;
                bus.packet2 <= byte2_r;
                bus.packet3 <= bus.rx_data;
            end else begin
                bus.packet1 <= bus.packet1;
                bus.packet2 <= bus.packet2;
                bus.packet3 <= bus.packet3;
            end
            bus.packet_done <= emit_s;
            bus.sync_err    <= err_s;
        end
    end

endmodule
